// File: rtl/multi_clock_ctrl.sv
// Clock, NUM_ALARMS alarms and stopwatch behind a key-driven mode FSM; key effects land 3 clks after key_n falls.
// No backpressure: keys are one-shot presses and tick_1hz is consumed in the cycle it arrives.
module multi_clock_ctrl #(
    parameter int NUM_ALARMS    = 4,
    parameter int HOURS_PER_DAY = 24,
    parameter int INIT_HOUR     = 5,
    parameter int INIT_MINUTE   = 3,
    parameter int INIT_SECOND   = 21,
    parameter int RING_SECONDS  = 60
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tick_1hz,
    input  logic [3:0]            key_n,
    input  logic                  clock_en,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    output logic [2:0]            mode,
    output logic [1:0]            field_sel,
    output logic [2:0]            alarm_idx,
    output logic [23:0]           disp_time,
    output logic                  sw_running,
    output logic                  alarm_ring,
    output logic [NUM_ALARMS-1:0] alarm_src,
    output logic                  blink
);
    typedef enum logic [2:0] {
        MODE_CLOCK      = 3'd0,
        MODE_TIME_SET   = 3'd1,
        MODE_STOPWATCH  = 3'd2,
        MODE_ALARM_VIEW = 3'd3,
        MODE_ALARM_SET  = 3'd4
    } mode_t;

    localparam logic [7:0]  HOUR_LAST = 8'(HOURS_PER_DAY - 1);
    localparam logic [7:0]  MS_LAST   = 8'd59;
    localparam logic [7:0]  SWH_LAST  = 8'd99;
    localparam logic [2:0]  IDX_LAST  = 3'(NUM_ALARMS - 1);
    localparam logic [15:0] RING_LAST = 16'(RING_SECONDS - 1);

    function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] last, input logic up);
        if (up) return (v == last) ? 8'd0 : v + 8'd1;
        else    return (v == 8'd0) ? last : v - 8'd1;
    endfunction

    mode_t                 mode_q, mode_d;
    logic [3:0]            key_s1, key_s2, key_q, press;
    logic                  k0, k1, k2, k3, k1_eff, dismiss, edit;
    logic [7:0]            clk_h, clk_m, clk_s, sw_h, sw_m, sw_s;
    logic [7:0]            al_h [8];
    logic [7:0]            al_m [8];
    logic [7:0]            al_s [8];
    logic [23:0]           clk_next, sw_next;
    logic                  clk_adv;
    logic [NUM_ALARMS-1:0] fire, src_kept;
    logic [15:0]           ring_cnt;

    // A press is the first cycle the synchronised key reads low; priority drops lower keys.
    assign press   = key_q & ~key_s2;
    assign k0      = press[0];
    assign k1      = press[1] & ~press[0];
    assign k2      = press[2] & ~|press[1:0];
    assign k3      = press[3] & ~|press[2:0];
    assign dismiss = k1 & alarm_ring;
    assign k1_eff  = k1 & ~alarm_ring;
    assign edit    = k2 | k3;

    assign clk_adv  = tick_1hz & clock_en & (mode_q != MODE_TIME_SET);
    assign src_kept = alarm_src & alarm_en;

    always_comb begin
        clk_next = {clk_h, clk_m, step(clk_s, MS_LAST, 1'b1)};
        if (clk_s == MS_LAST) begin
            clk_next[15:8] = step(clk_m, MS_LAST, 1'b1);
            if (clk_m == MS_LAST) clk_next[23:16] = step(clk_h, HOUR_LAST, 1'b1);
        end
        sw_next = {sw_h, sw_m, step(sw_s, MS_LAST, 1'b1)};
        if (sw_s == MS_LAST) begin
            sw_next[15:8] = step(sw_m, MS_LAST, 1'b1);
            if (sw_m == MS_LAST) sw_next[23:16] = step(sw_h, SWH_LAST, 1'b1);
        end
        fire = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            fire[i] = clk_adv & alarm_en[i] & ({al_h[i], al_m[i], al_s[i]} == clk_next);
    end

    always_comb begin
        mode_d = mode_q;
        if (k0) begin
            case (mode_q)
                MODE_CLOCK:     mode_d = MODE_TIME_SET;
                MODE_TIME_SET:  mode_d = MODE_STOPWATCH;
                MODE_STOPWATCH: mode_d = MODE_ALARM_VIEW;
                default:        mode_d = MODE_CLOCK;
            endcase
        end else if (k1_eff) begin
            if (mode_q == MODE_ALARM_VIEW)
                mode_d = MODE_ALARM_SET;
            else if (mode_q == MODE_ALARM_SET && field_sel == 2'd2)
                mode_d = MODE_ALARM_VIEW;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mode_q <= MODE_CLOCK;
        else       mode_q <= mode_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_s1     <= 4'hF;
            key_s2     <= 4'hF;
            key_q      <= 4'hF;
            field_sel  <= 2'd0;
            alarm_idx  <= 3'd0;
            clk_h      <= 8'(INIT_HOUR);
            clk_m      <= 8'(INIT_MINUTE);
            clk_s      <= 8'(INIT_SECOND);
            sw_h       <= 8'd0;
            sw_m       <= 8'd0;
            sw_s       <= 8'd0;
            sw_running <= 1'b0;
            alarm_ring <= 1'b0;
            alarm_src  <= '0;
            ring_cnt   <= 16'd0;
            blink      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                al_h[i] <= 8'd0;
                al_m[i] <= 8'd0;
                al_s[i] <= 8'd0;
            end
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            key_q  <= key_s2;
            if (tick_1hz) blink <= ~blink;

            if (mode_d != mode_q && (mode_d == MODE_TIME_SET || mode_d == MODE_ALARM_SET))
                field_sel <= 2'd0;
            else if (k1_eff && (mode_q == MODE_TIME_SET || (mode_q == MODE_ALARM_SET && field_sel != 2'd2)))
                field_sel <= (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;

            if (mode_q == MODE_TIME_SET && edit) begin
                case (field_sel)
                    2'd0:    clk_h <= step(clk_h, HOUR_LAST, k2);
                    2'd1:    clk_m <= step(clk_m, MS_LAST, k2);
                    default: clk_s <= step(clk_s, MS_LAST, k2);
                endcase
            end else if (clk_adv) begin
                {clk_h, clk_m, clk_s} <= clk_next;
            end

            if (mode_q == MODE_STOPWATCH && k2)
                sw_running <= ~sw_running;
            if (mode_q == MODE_STOPWATCH && k3 && !sw_running)
                {sw_h, sw_m, sw_s} <= 24'd0;
            else if (sw_running && tick_1hz)
                {sw_h, sw_m, sw_s} <= sw_next;

            if (mode_q == MODE_ALARM_VIEW && k2)
                alarm_idx <= (alarm_idx == IDX_LAST) ? 3'd0 : alarm_idx + 3'd1;
            else if (mode_q == MODE_ALARM_VIEW && k3)
                alarm_idx <= (alarm_idx == 3'd0) ? IDX_LAST : alarm_idx - 3'd1;

            if (mode_q == MODE_ALARM_SET && edit) begin
                case (field_sel)
                    2'd0:    al_h[alarm_idx] <= step(al_h[alarm_idx], HOUR_LAST, k2);
                    2'd1:    al_m[alarm_idx] <= step(al_m[alarm_idx], MS_LAST, k2);
                    default: al_s[alarm_idx] <= step(al_s[alarm_idx], MS_LAST, k2);
                endcase
            end

            // A fresh fire restarts the ring window; disabled channels drop out every cycle.
            if (dismiss) begin
                alarm_src  <= '0;
                alarm_ring <= 1'b0;
            end else if (|fire) begin
                alarm_src  <= src_kept | fire;
                alarm_ring <= 1'b1;
                ring_cnt   <= 16'd0;
            end else if (alarm_ring && tick_1hz && ring_cnt == RING_LAST) begin
                alarm_src  <= '0;
                alarm_ring <= 1'b0;
            end else begin
                alarm_src <= src_kept;
                if (src_kept == '0)
                    alarm_ring <= 1'b0;
                else if (alarm_ring && tick_1hz)
                    ring_cnt <= ring_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        case (mode_q)
            MODE_STOPWATCH:                  disp_time = {sw_h, sw_m, sw_s};
            MODE_ALARM_VIEW, MODE_ALARM_SET: disp_time = {al_h[alarm_idx], al_m[alarm_idx], al_s[alarm_idx]};
            default:                         disp_time = {clk_h, clk_m, clk_s};
        endcase
    end

    assign mode = mode_q;
endmodule

// File: tb/tb_multi_clock_ctrl.sv
// Directed bench for multi_clock_ctrl: key sequences and 1 Hz ticks with hand-computed expected values.
module tb_multi_clock_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        tick_1hz;
    logic [3:0]  key_n;
    logic        clock_en;
    logic [3:0]  alarm_en;
    logic [2:0]  mode;
    logic [1:0]  field_sel;
    logic [2:0]  alarm_idx;
    logic [23:0] disp_time;
    logic        sw_running;
    logic        alarm_ring;
    logic [3:0]  alarm_src;
    logic        blink;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_clock_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .tick_1hz   (tick_1hz),
        .key_n      (key_n),
        .clock_en   (clock_en),
        .alarm_en   (alarm_en),
        .mode       (mode),
        .field_sel  (field_sel),
        .alarm_idx  (alarm_idx),
        .disp_time  (disp_time),
        .sw_running (sw_running),
        .alarm_ring (alarm_ring),
        .alarm_src  (alarm_src),
        .blink      (blink)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return {8'h00, 8'(h), 8'(m), 8'(s)};
    endfunction

    task automatic press_mask(input logic [3:0] m);
        @(negedge clk);
        key_n = ~m;
        repeat (4) @(negedge clk);
        key_n = 4'hF;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input int k, input int n = 1);
        for (int i = 0; i < n; i++) press_mask(4'(1 << k));
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_1hz = 1'b1;
            @(negedge clk);
            tick_1hz = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn     = 1'b0;
        tick_1hz = 1'b0;
        key_n    = 4'hF;
        clock_en = 1'b0;
        alarm_en = 4'b0000;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        check_val("rst_mode",  32'(mode), 32'd0);
        check_val("rst_field", 32'(field_sel), 32'd0);
        check_val("rst_idx",   32'(alarm_idx), 32'd0);
        check_val("rst_time",  32'(disp_time), hms(5, 3, 21));
        check_val("rst_ring",  32'(alarm_ring), 32'd0);
        check_val("rst_src",   32'(alarm_src), 32'd0);
        check_val("rst_blink", 32'(blink), 32'd0);
        check_val("rst_sw",    32'(sw_running), 32'd0);

        clock_en = 1'b1;
        tick_n(3);
        check_val("run3_time",  32'(disp_time), hms(5, 3, 24));
        check_val("run3_mode",  32'(mode), 32'd0);
        check_val("run3_ring",  32'(alarm_ring), 32'd0);
        check_val("run3_blink", 32'(blink), 32'd1);

        // Time set: hour down, then second up across 59
        press(0);
        check_val("ts_mode",  32'(mode), 32'd1);
        check_val("ts_field", 32'(field_sel), 32'd0);
        press(3);
        check_val("ts_hour_dec", 32'(disp_time), hms(4, 3, 24));
        press(1, 2);
        check_val("ts_field_sec", 32'(field_sel), 32'd2);
        press(3, 25);
        check_val("ts_sec_59", 32'(disp_time), hms(4, 3, 59));
        press(2);
        check_val("ts_sec_wrap", 32'(disp_time), hms(4, 3, 0));
        tick_n(5);
        check_val("ts_frozen", 32'(disp_time), hms(4, 3, 0));
        check_val("ts_blink",  32'(blink), 32'd0);

        // Preset 23:59:58 and roll over midnight
        press(1);
        check_val("ts_field_wrap", 32'(field_sel), 32'd0);
        press(3, 5);
        check_val("ts_hour_wrap", 32'(disp_time), hms(23, 3, 0));
        press(1);
        press(3, 4);
        press(1);
        press(3, 2);
        check_val("ts_preset", 32'(disp_time), hms(23, 59, 58));
        press(0, 3);
        check_val("back_clock", 32'(mode), 32'd0);
        check_val("preset_kept", 32'(disp_time), hms(23, 59, 58));
        tick_n(1);
        check_val("tick_5959", 32'(disp_time), hms(23, 59, 59));
        tick_n(1);
        check_val("midnight", 32'(disp_time), hms(0, 0, 0));

        // Simultaneous key0+key2 in TIME_SET: only the mode moves
        press(0);
        check_val("sim_pre_mode", 32'(mode), 32'd1);
        press_mask(4'b0101);
        check_val("sim_mode", 32'(mode), 32'd2);
        check_val("sim_sw",   32'(sw_running), 32'd0);
        check_val("sim_swt",  32'(disp_time), hms(0, 0, 0));
        press(0, 2);
        check_val("sim_clock", 32'(disp_time), hms(0, 0, 0));

        // Stopwatch
        press(0, 2);
        check_val("sw_mode", 32'(mode), 32'd2);
        press(2);
        check_val("sw_run", 32'(sw_running), 32'd1);
        tick_n(3);
        check_val("sw_3s", 32'(disp_time), hms(0, 0, 3));
        press(3);
        check_val("sw_clr_ign", 32'(disp_time), hms(0, 0, 3));
        press(2);
        check_val("sw_stop", 32'(sw_running), 32'd0);
        press(3);
        check_val("sw_clr", 32'(disp_time), hms(0, 0, 0));
        press(2);
        press(0);
        check_val("sw_av_mode", 32'(mode), 32'd3);
        tick_n(2);
        press(0, 3);
        check_val("sw_bg_count", 32'(disp_time), hms(0, 0, 2));
        check_val("sw_bg_run", 32'(sw_running), 32'd1);

        // Reset in the middle of a key press
        @(negedge clk);
        key_n = 4'b1110;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        key_n = 4'hF;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_val("mid_rst_mode", 32'(mode), 32'd0);
        check_val("mid_rst_time", 32'(disp_time), hms(5, 3, 21));
        check_val("mid_rst_sw",   32'(sw_running), 32'd0);

        // Program alarm[2] = 05:03:25 with no ticks running
        press(0, 3);
        check_val("av_mode", 32'(mode), 32'd3);
        press(2, 2);
        check_val("av_idx2", 32'(alarm_idx), 32'd2);
        press(3, 3);
        check_val("av_idx_dnwrap", 32'(alarm_idx), 32'd3);
        press(2);
        check_val("av_idx_upwrap", 32'(alarm_idx), 32'd0);
        press(2, 2);
        press(1);
        check_val("as_mode",  32'(mode), 32'd4);
        check_val("as_field", 32'(field_sel), 32'd0);
        press(2, 5);
        press(1);
        press(2, 3);
        press(1);
        press(2, 25);
        check_val("as_value", 32'(disp_time), hms(5, 3, 25));
        press(1);
        check_val("as_back_av", 32'(mode), 32'd3);
        press(0);
        check_val("al_clock", 32'(disp_time), hms(5, 3, 21));

        alarm_en = 4'b0100;
        tick_n(3);
        check_val("al_pre_ring", 32'(alarm_ring), 32'd0);
        tick_n(1);
        check_val("al_ring", 32'(alarm_ring), 32'd1);
        check_val("al_src",  32'(alarm_src), 32'h4);
        press(1);
        check_val("dis_ring",  32'(alarm_ring), 32'd0);
        check_val("dis_src",   32'(alarm_src), 32'd0);
        check_val("dis_mode",  32'(mode), 32'd0);

        // Rewind the clock to 05:03:21 and let the ring time out
        press(0);
        press(1, 2);
        press(3, 4);
        press(0, 3);
        check_val("rew_clock", 32'(disp_time), hms(5, 3, 21));
        tick_n(4);
        check_val("re_ring", 32'(alarm_ring), 32'd1);
        tick_n(59);
        check_val("ring_59", 32'(alarm_ring), 32'd1);
        tick_n(1);
        check_val("ring_60", 32'(alarm_ring), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
